// File: rtl/stage_sequencer_pkg.sv
// Shared constants for the stage sequencer and the signal generation unit.
//   - STAGE_* : stage codes carried on pipeline_stage (STAGE_COUNT bits).
//   - TYPE_*  : one-hot decoded instruction types (OPCODE_COUNT bits).
//   - GROUP_* : bit positions in the decoded group flag vector.
//   - is_mem_type(): true for the types that need a data-bus access.
package stage_sequencer_pkg;

    localparam int OPCODE_COUNT = 8;
    localparam int GROUP_COUNT  = 4;
    localparam int STAGE_COUNT  = 3;

    localparam logic [STAGE_COUNT-1:0] STAGE_IF   = 3'd0;
    localparam logic [STAGE_COUNT-1:0] STAGE_ID   = 3'd1;
    localparam logic [STAGE_COUNT-1:0] STAGE_EX   = 3'd2;
    localparam logic [STAGE_COUNT-1:0] STAGE_MEM  = 3'd3;
    localparam logic [STAGE_COUNT-1:0] STAGE_WB   = 3'd4;
    localparam logic [STAGE_COUNT-1:0] STAGE_IF2  = 3'd5;
    localparam logic [STAGE_COUNT-1:0] STAGE_HALT = 3'd6;

    localparam logic [OPCODE_COUNT-1:0] TYPE_ALU     = 8'h01;
    localparam logic [OPCODE_COUNT-1:0] TYPE_ALU_IMM = 8'h02;
    localparam logic [OPCODE_COUNT-1:0] TYPE_BRANCH  = 8'h04;
    localparam logic [OPCODE_COUNT-1:0] TYPE_JUMP    = 8'h08;
    localparam logic [OPCODE_COUNT-1:0] TYPE_LD_Y    = 8'h10;
    localparam logic [OPCODE_COUNT-1:0] TYPE_LDS     = 8'h20;
    localparam logic [OPCODE_COUNT-1:0] TYPE_STS     = 8'h40;
    localparam logic [OPCODE_COUNT-1:0] TYPE_NOP     = 8'h80;

    localparam int GROUP_ALU    = 0;
    localparam int GROUP_BRANCH = 1;
    localparam int GROUP_LOAD   = 2;
    localparam int GROUP_STORE  = 3;

    // Types that go through MEM; shared with the signal generation unit.
    localparam logic [OPCODE_COUNT-1:0] GROUP_MEM_TYPES = TYPE_LD_Y | TYPE_LDS | TYPE_STS;

    typedef enum logic [STAGE_COUNT-1:0] {
        ST_IF   = STAGE_IF,
        ST_ID   = STAGE_ID,
        ST_EX   = STAGE_EX,
        ST_MEM  = STAGE_MEM,
        ST_WB   = STAGE_WB,
        ST_IF2  = STAGE_IF2,
        ST_HALT = STAGE_HALT
    } stage_e;

    function automatic logic is_mem_type(input logic [OPCODE_COUNT-1:0] t);
        return (t == TYPE_LD_Y) || (t == TYPE_LDS) || (t == TYPE_STS);
    endfunction

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts MEM cycles that end without mem_ready.
//   clk, reset  : clock, async active-low reset
//   clear       : zero the count (held while not in MEM)
//   enable      : a MEM cycle without completion; count advances
//   limit       : cycle limit (1..255)
//   expired     : this enabled cycle brings the count up to limit
module mem_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    // Look-ahead compare so the sequencer can leave MEM on the same edge
    // that the count would reach the limit.
    assign expired = enable && ((count + 8'd1) == limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 8'd1;
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle stage controller for the lab CPU.
// Steps IF, ID, [IF2, ID], EX, [MEM], WB; parks in HALT on request
// or on a bus timeout.
//   clk, reset      : clock, async active-low reset
//   opcode_type     : one-hot decoded type (used in EX)
//   opcode_group    : decoded group flags (not needed for sequencing)
//   instr_two_word  : instruction has a second word
//   mem_ready       : data access completes this cycle (MEM only)
//   halt            : halt request, sampled in WB and HALT
//   pipeline_stage  : current stage code
//   fetch_second    : high in IF2
//   pc_advance      : high in IF and IF2
//   instr_retired   : high in WB
//   mem_timeout     : sticky bus timeout, cleared by reset only
//   retired_count   : retired instruction count, wraps
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [GROUP_COUNT-1:0]  opcode_group,
    input  logic                    instr_two_word,
    input  logic                    mem_ready,
    input  logic                    halt,
    output logic [STAGE_COUNT-1:0]  pipeline_stage,
    output logic                    fetch_second,
    output logic                    pc_advance,
    output logic                    instr_retired,
    output logic                    mem_timeout,
    output logic [15:0]             retired_count
);

    stage_e state;
    logic   second_done;
    logic   wait_expired;

    logic unused_group;
    assign unused_group = ^opcode_group;

    // Counter idles at zero outside MEM, so every MEM entry starts fresh.
    mem_wait_timer u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_MEM),
        .enable  ((state == ST_MEM) && !mem_ready),
        .limit   (8'(MEM_WAIT_MAX)),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IF;
            second_done   <= 1'b0;
            mem_timeout   <= 1'b0;
            retired_count <= '0;
        end else begin
            unique case (state)
                ST_IF:  state <= ST_ID;
                ST_ID:  state <= (instr_two_word && !second_done) ? ST_IF2 : ST_EX;
                ST_IF2: begin
                    state       <= ST_ID;
                    second_done <= 1'b1;
                end
                ST_EX:  state <= is_mem_type(opcode_type) ? ST_MEM : ST_WB;
                ST_MEM: begin
                    // Completion wins over a timeout in the same cycle.
                    if (mem_ready) begin
                        state <= ST_WB;
                    end else if (wait_expired) begin
                        state       <= ST_HALT;
                        mem_timeout <= 1'b1;
                    end
                end
                ST_WB: begin
                    retired_count <= retired_count + 16'd1;
                    second_done   <= 1'b0;
                    state         <= halt ? ST_HALT : ST_IF;
                end
                ST_HALT: if (!halt && !mem_timeout) state <= ST_IF;
                default: state <= ST_IF;
            endcase
        end
    end

    assign pipeline_stage = state;
    assign fetch_second   = (state == ST_IF2);
    assign pc_advance     = (state == ST_IF) || (state == ST_IF2);
    assign instr_retired  = (state == ST_WB);

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int WMAX = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [OPCODE_COUNT-1:0] opcode_type = '0;
    logic [GROUP_COUNT-1:0]  opcode_group = '0;
    logic                    instr_two_word = 1'b0;
    logic                    mem_ready = 1'b0;
    logic                    halt = 1'b0;
    logic [STAGE_COUNT-1:0]  pipeline_stage;
    logic                    fetch_second;
    logic                    pc_advance;
    logic                    instr_retired;
    logic                    mem_timeout;
    logic [15:0]             retired_count;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_count = '0;

    stage_sequencer #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode_type    (opcode_type),
        .opcode_group   (opcode_group),
        .instr_two_word (instr_two_word),
        .mem_ready      (mem_ready),
        .halt           (halt),
        .pipeline_stage (pipeline_stage),
        .fetch_second   (fetch_second),
        .pc_advance     (pc_advance),
        .instr_retired  (instr_retired),
        .mem_timeout    (mem_timeout),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outs(input logic [STAGE_COUNT-1:0] s, input logic to);
        chk("stage", 32'(pipeline_stage), 32'(s));
        chk("pc_advance", 32'(pc_advance), 32'((s == STAGE_IF) || (s == STAGE_IF2)));
        chk("fetch_second", 32'(fetch_second), 32'(s == STAGE_IF2));
        chk("instr_retired", 32'(instr_retired), 32'(s == STAGE_WB));
        chk("mem_timeout", 32'(mem_timeout), 32'(to));
        chk("retired_count", 32'(retired_count), 32'(exp_count));
    endtask

    function automatic bit ref_is_mem(input logic [OPCODE_COUNT-1:0] t);
        return (t == TYPE_LD_Y) || (t == TYPE_LDS) || (t == TYPE_STS);
    endfunction

    // Called at a falling edge with the DUT in IF. rdy_at: MEM cycle
    // (1-based) that sees mem_ready, 0 = never. noisy: random halt and
    // mem_ready where they must be ignored. halt_early: halt high in EX/MEM.
    task automatic run_instr(input logic [OPCODE_COUNT-1:0] typ, input bit tw,
                             input int rdy_at, input bit halt_wb,
                             input bit noisy, input bit halt_early);
        logic [STAGE_COUNT-1:0] seq[$];
        logic [STAGE_COUNT-1:0] s;
        bit timed = 1'b0;
        int mem_idx = 0;
        seq = {STAGE_IF, STAGE_ID};
        if (tw) seq = {seq, STAGE_IF2, STAGE_ID};
        seq.push_back(STAGE_EX);
        if (ref_is_mem(typ)) begin
            timed = (rdy_at == 0) || (rdy_at > WMAX);
            repeat (timed ? WMAX : rdy_at) seq.push_back(STAGE_MEM);
        end
        if (!timed) seq.push_back(STAGE_WB);

        foreach (seq[k]) begin
            s = seq[k];
            chk_outs(s, 1'b0);
            opcode_type    = typ;
            instr_two_word = tw;
            opcode_group   = GROUP_COUNT'($urandom);
            if (s == STAGE_MEM) begin
                mem_idx++;
                mem_ready = (mem_idx == rdy_at);
            end else begin
                mem_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (s == STAGE_WB)
                halt = halt_wb;
            else if (halt_early && (s == STAGE_EX || s == STAGE_MEM))
                halt = 1'b1;
            else
                halt = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (s == STAGE_WB) exp_count = exp_count + 16'd1;
        end

        if (timed) begin
            // Timeout halt ignores halt=0; only reset leaves it.
            repeat (3) begin
                chk_outs(STAGE_HALT, 1'b1);
                halt      = 1'b0;
                mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            #2 reset = 1'b0;
            #1 exp_count = '0;
            chk_outs(STAGE_IF, 1'b0);
            @(negedge clk);
            reset = 1'b1;
        end else if (halt_wb) begin
            repeat ($urandom_range(0, 2)) begin
                chk_outs(STAGE_HALT, 1'b0);
                halt = 1'b1;
                @(negedge clk);
            end
            chk_outs(STAGE_HALT, 1'b0);
            halt = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [OPCODE_COUNT-1:0] typ;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs(STAGE_IF, 1'b0);
        reset = 1'b1;

        // Directed cases
        run_instr(TYPE_ALU,   1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(TYPE_LD_Y,  1'b0, 3, 1'b0, 1'b0, 1'b0);
        run_instr(TYPE_LDS,   1'b1, 1, 1'b0, 1'b0, 1'b0);
        run_instr(TYPE_LD_Y,  1'b0, WMAX, 1'b0, 1'b1, 1'b0);
        run_instr(TYPE_ALU,   1'b0, 0, 1'b1, 1'b0, 1'b1);
        run_instr(TYPE_BRANCH,1'b0, 0, 1'b0, 1'b0, 1'b1);
        run_instr(TYPE_STS,   1'b1, 0, 1'b0, 1'b0, 1'b0);
        run_instr(TYPE_ALU,   1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            typ = '0;
            typ[$urandom_range(0, OPCODE_COUNT - 1)] = 1'b1;
            run_instr(typ, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 1)));
        end

        // Retire counter wrap
        force dut.retired_count = 16'hFFFF;
        #1 release dut.retired_count;
        exp_count = 16'hFFFF;
        run_instr(TYPE_ALU_IMM, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", 32'(retired_count), 32'h0);

        // Async reset while MEM waits on the bus
        opcode_type = TYPE_LD_Y; instr_two_word = 1'b0; mem_ready = 1'b0; halt = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mem_stage", 32'(pipeline_stage), 32'(STAGE_MEM));
        #2 reset = 1'b0;
        #1 exp_count = '0;
        chk_outs(STAGE_IF, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run_instr(TYPE_NOP, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
